// File: rtl/hmmm_loader_pkg.sv
// hmmm_loader_pkg: shared types and constants for the HMMM boot loader.
//   loader_state_t : loader FSM states (CHK/ERR are used only when the
//                    checksum build option HMMM_LOADER_CHECKSUM_EN is defined)
//   BYTES_PER_WORD : image bytes per SRAM word (high byte first)
//   sram_ctl_t     : active-low SRAM control triple (ce_n, oe_n, we_n)
//   SRAM_IDLE      : chip selected, no read, no write
//   SRAM_WRITE     : loader write cycle
//   core_ctl()     : control triple the core implies through MemWrite
package hmmm_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        CHK   = 3'd4,
        ERR   = 3'd5,
        DONE  = 3'd6
    } loader_state_t;

    localparam int STATE_W        = $bits(loader_state_t);
    localparam int BYTES_PER_WORD = 2;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } sram_ctl_t;

    localparam sram_ctl_t SRAM_IDLE  = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
    localparam sram_ctl_t SRAM_WRITE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};

    // The core either writes (we_n low) or reads (oe_n low) every cycle.
    function automatic sram_ctl_t core_ctl(input logic memwrite);
        return '{ce_n: 1'b0, oe_n: memwrite, we_n: ~memwrite};
    endfunction

endpackage

// File: rtl/hmmm_boot_loader_if.sv
// hmmm_boot_loader_if: byte link, core bus and SRAM bus of the boot loader.
//   rx_valid/rx_byte/rx_ready : byte stream handshake (accept on valid&ready)
//   core_adr/core_memwrite    : core address and MemWrite
//   core_reset                : reset to the core, released after the load
//   sram_adr/sram_wdata       : SRAM address and loader write data
//   ld_drive                  : loader drives the SRAM data bus (tristate enable)
//   sram_ce_n/oe_n/we_n       : active-low SRAM controls
//   load_done/load_err        : load complete / checksum failure
// Modports: master = loader, slave = board/core/SRAM side.
interface hmmm_boot_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] core_adr;
    logic                  core_memwrite;
    logic                  core_reset;
    logic [ADDR_WIDTH-1:0] sram_adr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic                  ld_drive;
    logic                  sram_ce_n;
    logic                  sram_oe_n;
    logic                  sram_we_n;
    logic                  load_done;
    logic                  load_err;

    modport master (
        input  rx_valid, rx_byte, core_adr, core_memwrite,
        output rx_ready, core_reset, sram_adr, sram_wdata, ld_drive,
               sram_ce_n, sram_oe_n, sram_we_n, load_done, load_err
    );

    modport slave (
        output rx_valid, rx_byte, core_adr, core_memwrite,
        input  rx_ready, core_reset, sram_adr, sram_wdata, ld_drive,
               sram_ce_n, sram_oe_n, sram_we_n, load_done, load_err
    );
endinterface

// File: rtl/loader_bus_mux.sv
// loader_bus_mux: selects who drives the SRAM address and controls.
// Until the image is loaded the loader owns the bus; afterwards the core's
// address and MemWrite pass straight through and the loader's data driver
// is switched off.
//   core_owns                  : 1 once the load has completed
//   loader_adr/ctl/drive       : loader address, control triple, data enable
//   core_adr, core_memwrite    : core address and write strobe
//   sram_adr/ctl/drive         : selected SRAM address, controls, data enable
module loader_bus_mux
    import hmmm_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  core_owns,
    input  logic [ADDR_WIDTH-1:0] loader_adr,
    input  sram_ctl_t             loader_ctl,
    input  logic                  loader_drive,
    input  logic [ADDR_WIDTH-1:0] core_adr,
    input  logic                  core_memwrite,
    output logic [ADDR_WIDTH-1:0] sram_adr,
    output sram_ctl_t             sram_ctl,
    output logic                  sram_drive
);
    always_comb begin
        sram_adr   = loader_adr;
        sram_ctl   = loader_ctl;
        sram_drive = loader_drive;
        if (core_owns) begin
            sram_adr   = core_adr;
            sram_ctl   = core_ctl(core_memwrite);
            sram_drive = 1'b0;
        end
    end
endmodule

// File: rtl/loader_flop2ph.sv
// loader_flop2ph: two-phase resettable register matching the core flops.
// The master stage samples d (or RESET_VAL while reset is high) in ph2; the
// slave stage presents it on q in the following ph1.
//   ph1, ph2 : non-overlapping phase clocks
//   reset    : synchronous, active-high, sampled in ph2
//   d, q     : WIDTH-bit data in / registered data out
module loader_flop2ph #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] master_reg;

    always_ff @(posedge ph2) begin
        master_reg <= reset ? RESET_VAL : d;
    end

    always_ff @(posedge ph1) begin
        q <= master_reg;
    end
endmodule

// File: rtl/hmmm_boot_loader.sv
// hmmm_boot_loader: loads a program image from the byte link into SRAM,
// then hands the SRAM bus to the core and releases core reset.
// Image format: count byte N (0 means 2^ADDR_WIDTH words), then N words,
// high byte first. Words are written from address 0 upward, wrapping.
// Build option HMMM_LOADER_CHECKSUM_EN: one extra byte after the image must
// equal the mod-256 sum of all data bytes; a mismatch parks the loader in ERR
// with load_err=1 and the core held in reset.
//   ph1, ph2 : two-phase clocks (state samples in ph2, updates in ph1)
//   reset    : synchronous, active-high, sampled in ph2
//   bus      : hmmm_boot_loader_if master (byte link, core bus, SRAM bus)
// DATA_WIDTH must equal 8*BYTES_PER_WORD.
module hmmm_boot_loader
    import hmmm_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic               ph1,
    input  logic               ph2,
    input  logic               reset,
    hmmm_boot_loader_if.master bus
);
    loader_state_t         state_reg, state_next;
    logic [STATE_W-1:0]    state_q;
    logic [ADDR_WIDTH-1:0] words_reg, words_next;
    logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
`ifdef HMMM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_reg, sum_next;
    logic                  load_err_int;
`endif

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       data_take;
    logic       rx_ready_int;
    logic       core_reset_int;
    logic       load_done_int;
    logic       core_owns;
    logic       loader_drive;
    sram_ctl_t  loader_ctl;

    logic [ADDR_WIDTH-1:0] sram_adr;
    sram_ctl_t             sram_ctl;
    logic                  sram_drive;

    assign rx_valid = bus.rx_valid;
    assign rx_byte  = bus.rx_byte;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    loader_flop2ph #(.WIDTH(STATE_W), .RESET_VAL(STATE_W'(IDLE))) u_state_flop (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(state_next), .q(state_q)
    );
    assign state_reg = loader_state_t'(state_q);

    loader_flop2ph #(.WIDTH(ADDR_WIDTH)) u_words_flop (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(words_next), .q(words_reg)
    );

    loader_flop2ph #(.WIDTH(ADDR_WIDTH)) u_adr_flop (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(adr_next), .q(adr_reg)
    );

    loader_flop2ph #(.WIDTH(BYTE_CNT_W)) u_byte_cnt_flop (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(byte_cnt_next), .q(byte_cnt_reg)
    );

    loader_flop2ph #(.WIDTH(DATA_WIDTH)) u_wdata_flop (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(wdata_next), .q(wdata_reg)
    );

`ifdef HMMM_LOADER_CHECKSUM_EN
    loader_flop2ph #(.WIDTH(8)) u_sum_flop (
        .ph1(ph1), .ph2(ph2), .reset(reset), .d(sum_next), .q(sum_reg)
    );
`endif

    // ------------------------------------------------------------------
    // Word assembly: byte_cnt counts data bytes within the current word;
    // the first byte lands in the most significant lane.
    // ------------------------------------------------------------------
    assign data_take = rx_valid && ((state_reg == HI) || (state_reg == LO));

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        localparam logic [BYTE_CNT_W-1:0] FILL_AT = BYTE_CNT_W'(BYTES_PER_WORD - 1 - gi);
        assign wdata_next[gi*8 +: 8] = (data_take && (byte_cnt_reg == FILL_AT))
                                       ? rx_byte : wdata_reg[gi*8 +: 8];
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        words_next     = words_reg;
        adr_next       = adr_reg;
        byte_cnt_next  = byte_cnt_reg;
`ifdef HMMM_LOADER_CHECKSUM_EN
        sum_next       = sum_reg;
        load_err_int   = 1'b0;
`endif
        rx_ready_int   = 1'b0;
        loader_ctl     = SRAM_IDLE;
        loader_drive   = 1'b0;
        core_reset_int = 1'b1;
        load_done_int  = 1'b0;
        core_owns      = 1'b0;

        case (state_reg)
            IDLE: begin
                rx_ready_int = 1'b1;
                if (rx_valid) begin
                    // N=0 wraps the decrement below into a full 2^ADDR_WIDTH load.
                    words_next    = ADDR_WIDTH'(rx_byte);
                    byte_cnt_next = '0;
                    state_next    = HI;
                end
            end
            HI: begin
                rx_ready_int = 1'b1;
                if (rx_valid) begin
                    byte_cnt_next = byte_cnt_reg + BYTE_CNT_W'(1);
`ifdef HMMM_LOADER_CHECKSUM_EN
                    sum_next      = sum_reg + rx_byte;
`endif
                    state_next    = LO;
                end
            end
            LO: begin
                rx_ready_int = 1'b1;
                if (rx_valid) begin
                    byte_cnt_next = '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    sum_next      = sum_reg + rx_byte;
`endif
                    state_next    = WRITE;
                end
            end
            WRITE: begin
                loader_ctl   = SRAM_WRITE;
                loader_drive = 1'b1;
                adr_next     = adr_reg + ADDR_WIDTH'(1);
                words_next   = words_reg - ADDR_WIDTH'(1);
                if (words_reg == ADDR_WIDTH'(1)) begin
`ifdef HMMM_LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = HI;
                end
            end
            CHK: begin
`ifdef HMMM_LOADER_CHECKSUM_EN
                rx_ready_int = 1'b1;
                if (rx_valid) begin
                    state_next = (rx_byte == sum_reg) ? DONE : ERR;
                end
`else
                state_next = IDLE;
`endif
            end
            ERR: begin
`ifdef HMMM_LOADER_CHECKSUM_EN
                load_err_int = 1'b1;
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                core_reset_int = 1'b0;
                load_done_int  = 1'b1;
                core_owns      = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    loader_bus_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bus_mux (
        .core_owns     (core_owns),
        .loader_adr    (adr_reg),
        .loader_ctl    (loader_ctl),
        .loader_drive  (loader_drive),
        .core_adr      (bus.core_adr),
        .core_memwrite (bus.core_memwrite),
        .sram_adr      (sram_adr),
        .sram_ctl      (sram_ctl),
        .sram_drive    (sram_drive)
    );

    assign bus.rx_ready   = rx_ready_int;
    assign bus.core_reset = core_reset_int;
    assign bus.load_done  = load_done_int;
    assign bus.sram_adr   = sram_adr;
    assign bus.sram_wdata = wdata_reg;
    assign bus.ld_drive   = sram_drive;
    assign bus.sram_ce_n  = sram_ctl.ce_n;
    assign bus.sram_oe_n  = sram_ctl.oe_n;
    assign bus.sram_we_n  = sram_ctl.we_n;
`ifdef HMMM_LOADER_CHECKSUM_EN
    assign bus.load_err   = load_err_int;
`else
    assign bus.load_err   = 1'b0;
`endif

endmodule
